// File: rtl/alu_operand_entry_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_entry_pkg
// Shared definitions for the ALU operand-entry front end: entry-state
// encodings (also driven onto the green LEDs), the default debounce interval
// and the select width.
// -----------------------------------------------------------------------------
package alu_operand_entry_pkg;

  // Entry sequence: operand A, operand B, select, then show the result.
  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SEL  = 2'b10,
    S_SHOW = 2'b11
  } entry_state_e;

  // 10 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  localparam int SEL_W = 3;

endpackage : alu_operand_entry_pkg

// File: rtl/alu_operand_entry_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes a raw, bouncy, active-high pushbutton and accepts a new level
// only after the synchronized input has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles. Emits a one-cycle Press on an accepted
// 0->1 change, but only once the button has been seen released after reset.
//
// Ports
//   Clock  in   system clock, rising edge
//   Reset  in   asynchronous, active-high
//   Raw    in   raw button level, asynchronous to Clock
//   Level  out  debounced button level
//   Press  out  one-cycle pulse on an accepted press
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Raw,
  output logic Level,
  output logic Press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, sync_prev_q;
  logic             level_q, armed_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  logic             bounce;
  logic             qualify;
  logic [CNT_W-1:0] cnt_run;
  logic             done;

  // A change of the synchronized input restarts whatever run is being timed.
  assign bounce  = sync2_q ^ sync_prev_q;

  // Two kinds of run are timed with the same counter:
  //  - the input disagrees with the accepted level (a level change pending);
  //  - not yet armed and the input is low (proving the button is released,
  //    so a button held through reset release never produces a press).
  assign qualify = (sync2_q != level_q) || (!armed_q && !sync2_q);
  assign cnt_run = bounce ? '0 : cnt_q;
  assign done    = qualify && (cnt_run == LAST);

  // NOTE: every register below is updated with non-blocking assignments so all
  // flops sample the values from before the clock edge, like real hardware.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      level_q     <= 1'b0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= Raw;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      press_q     <= 1'b0;
      if (!qualify) begin
        cnt_q <= '0;
      end else if (done) begin
        cnt_q <= '0;
        if (sync2_q != level_q) begin
          level_q <= sync2_q;
          press_q <= sync2_q & armed_q;
        end else begin
          armed_q <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_run + CNT_W'(1);
      end
    end
  end

  assign Level = level_q;
  assign Press = press_q;

endmodule : key_debounce

// File: rtl/alu_operand_entry.sv
// -----------------------------------------------------------------------------
// alu_operand_entry
// Input side of the switch/ALU/hex-display path. Each debounced Enter press
// steps the entry sequence, latching operand A, operand B and the ALU select
// from the data switches; on arriving in S_SHOW the ALU result Q is captured
// once for the displays and held until the next sequence.
//
// Ports
//   Clock   in   system clock, rising edge
//   Reset   in   asynchronous, active-high; clears all state
//   Data    in   data switches, sampled on an accepted press
//   Enter   in   raw pushbutton (debounced internally)
//   Clear   in   raw clear button (synchronized, level-sensitive)
//   Q       in   ALU result, combinational function of A, B, Sel
//   A, B    out  latched operands
//   Sel     out  latched ALU select
//   Result  out  captured ALU result
//   State   out  current entry state
//   Valid   out  Result belongs to the current A/B/Sel
// -----------------------------------------------------------------------------
module alu_operand_entry
  import alu_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DATA_W          = 4,
  parameter int Q_W             = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data,
  input  logic              Enter,
  input  logic              Clear,
  input  logic [Q_W-1:0]    Q,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  Sel,
  output logic [Q_W-1:0]    Result,
  output logic [1:0]        State,
  output logic              Valid
);

  entry_state_e      state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [Q_W-1:0]    result_q, result_d;
  logic              valid_q, valid_d;

  logic              clear_s1_q, clear_s2_q;
  logic              enter_level;
  logic              press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .Clock(Clock),
    .Reset(Reset),
    .Raw  (Enter),
    .Level(enter_level),
    .Press(press)
  );

  // Clear is a level, so synchronizing it is enough; bounce only repeats it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clear_s1_q <= 1'b0;
      clear_s2_q <= 1'b0;
    end else begin
      clear_s1_q <= Clear;
      clear_s2_q <= clear_s1_q;
    end
  end

  // NOTE: every signal is given its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (clear_s2_q) begin
      // Clear wins over a press arriving in the same cycle.
      state_d  = S_A;
      a_d      = '0;
      b_d      = '0;
      sel_d    = '0;
      result_d = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_A: if (press) begin
          a_d     = Data;
          state_d = S_B;
        end
        S_B: if (press) begin
          b_d     = Data;
          state_d = S_SEL;
        end
        S_SEL: if (press) begin
          sel_d   = Data[SEL_W-1:0];
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (press) begin
            valid_d = 1'b0;
            state_d = S_A;
          end else if (!valid_q) begin
            // First cycle here: A/B/Sel have settled into the ALU, so Q is
            // the result for them. Valid then blocks any later recapture.
            result_d = Q;
            valid_d  = 1'b1;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign Sel    = sel_q;
  assign Result = result_q;
  assign State  = state_q;
  assign Valid  = valid_q;

endmodule : alu_operand_entry
